// File: rtl/mic1_pkg.sv
// Shared definitions for the MIC-1 control path: microinstruction control-field
// layout, default widths and the sequencing-operation decode.
package mic1_pkg;

  localparam int DEF_MPC_W       = 9;
  localparam int DEF_MBR_W       = 8;
  localparam int DEF_STACK_DEPTH = 4;

  localparam int RET_BIT       = 0;
  localparam int CALL_BIT      = 1;
  localparam int JAMZ_BIT      = 2;
  localparam int JAMN_BIT      = 3;
  localparam int JMPC_BIT      = 4;
  localparam int NEXT_ADDR_LSB = 5;

  typedef enum logic [1:0] {
    SEQ_PLAIN = 2'd0,
    SEQ_RET   = 2'd1,
    SEQ_CALL  = 2'd2,
    SEQ_SWAP  = 2'd3
  } seq_op_e;

  function automatic seq_op_e decode_op(input logic call, input logic ret);
    return seq_op_e'({call, ret});
  endfunction

endpackage

// File: rtl/mic1_ustack.sv
// Micro-return LIFO: push, pop and replace-top on a DEPTH x W array. Only the
// occupancy pointer is reset; entries beyond the pointer are meaningless.
module mic1_ustack #(
  parameter int DEPTH = 4,
  parameter int W     = 9,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     top,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] depth
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] top_idx_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic             do_push_s;
  logic             do_pop_s;
  logic             do_repl_s;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == {CNT_W{1'b0}});
  assign depth = cnt_q;
  assign top   = mem_q[top_idx_s];

  // Qualify requests against occupancy and pick the write slot.
  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    do_repl_s = replace & ~empty;
    if (empty) begin
      top_idx_s = {IDX_W{1'b0}};
    end else begin
      top_idx_s = IDX_W'(cnt_q - CNT_W'(1));
    end
    if (do_push_s) begin
      wr_idx_s = IDX_W'(cnt_q);
      cnt_d    = cnt_q + CNT_W'(1);
    end else if (do_pop_s) begin
      wr_idx_s = top_idx_s;
      cnt_d    = cnt_q - CNT_W'(1);
    end else begin
      wr_idx_s = top_idx_s;
      cnt_d    = cnt_q;
    end
  end

  // Occupancy pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, written on push or replace-top.
  always_ff @(posedge clock) begin
    if (do_push_s | do_repl_s) begin
      mem_q[wr_idx_s] <= din;
    end
  end

endmodule

// File: rtl/mic1_sequencer.sv
// MIC-1 next-address sequencer: jam/dispatch address computation, micro
// CALL/RET through a return stack, datapath stall and sticky stack-error flags.
module mic1_sequencer
  import mic1_pkg::*;
#(
  parameter int               MPC_W       = DEF_MPC_W,
  parameter int               MBR_W       = DEF_MBR_W,
  parameter int               STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [MPC_W-1:0] RESET_ADDR  = '0,
  localparam int              DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               n_flag,
  input  logic               z_flag,
  input  logic [MBR_W-1:0]   mbr,
  input  logic [MPC_W+4:0]   mir_ctrl,
  input  logic               stall,
  output logic [MPC_W-1:0]   mpc,
  output logic [DEPTH_W-1:0] stack_depth,
  output logic               stack_ovf,
  output logic               stack_unf
);

  logic [MPC_W-1:0] mpc_q, mpc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [MPC_W-1:0] next_addr_s;
  logic [MPC_W-1:0] ca_s;
  logic [MPC_W-1:0] ret_addr_s;
  logic [MPC_W-1:0] top_s;
  logic             jam_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             repl_s;

  mic1_ustack #(
    .DEPTH (STACK_DEPTH),
    .W     (MPC_W)
  ) u_stack (
    .clock   (clock),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .replace (repl_s),
    .din     (ret_addr_s),
    .top     (top_s),
    .full    (full_s),
    .empty   (empty_s),
    .depth   (stack_depth)
  );

  // Computed address and priority decode of the sequencing operation.
  always_comb begin
    next_addr_s = mir_ctrl[NEXT_ADDR_LSB +: MPC_W];
    jam_s       = (mir_ctrl[JAMN_BIT] & n_flag) | (mir_ctrl[JAMZ_BIT] & z_flag);
    ca_s        = next_addr_s;
    ca_s[MPC_W-1] = next_addr_s[MPC_W-1] | jam_s;
    // JMPC dispatch ORs MBR into the low bits rather than adding it.
    if (mir_ctrl[JMPC_BIT]) begin
      ca_s = ca_s | {{(MPC_W-MBR_W){1'b0}}, mbr};
    end else begin
      ca_s = ca_s;
    end
    ret_addr_s = mpc_q + {{(MPC_W-1){1'b0}}, 1'b1};
    mpc_d  = mpc_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    push_s = 1'b0;
    pop_s  = 1'b0;
    repl_s = 1'b0;
    if (stall) begin
      mpc_d = mpc_q;
    end else begin
      case (decode_op(mir_ctrl[CALL_BIT], mir_ctrl[RET_BIT]))
        SEQ_PLAIN: mpc_d = ca_s;
        SEQ_CALL: begin
          mpc_d  = ca_s;
          push_s = 1'b1;
          ovf_d  = ovf_q | full_s;
        end
        SEQ_RET: begin
          if (!empty_s) begin
            mpc_d = top_s;
            pop_s = 1'b1;
          end else begin
            mpc_d = ca_s;
            unf_d = 1'b1;
          end
        end
        SEQ_SWAP: begin
          if (!empty_s) begin
            mpc_d  = top_s;
            repl_s = 1'b1;
          end else begin
            mpc_d  = ca_s;
            push_s = 1'b1;
            unf_d  = 1'b1;
          end
        end
        default: mpc_d = ca_s;
      endcase
    end
  end

  // Program counter and sticky error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mpc_q <= RESET_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      mpc_q <= mpc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign mpc       = mpc_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_mic1_sequencer.sv
// Directed self-checking bench for mic1_sequencer: default 9/8-bit instance plus
// a 12/10-bit instance for the wide JMPC dispatch case.
module tb_mic1_sequencer;

  localparam logic [4:0] F_PLAIN = 5'b00000;
  localparam logic [4:0] F_JMPC  = 5'b10000;
  localparam logic [4:0] F_JAMN  = 5'b01000;
  localparam logic [4:0] F_JAMZ  = 5'b00100;
  localparam logic [4:0] F_CALL  = 5'b00010;
  localparam logic [4:0] F_RET   = 5'b00001;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        n_flag = 1'b0;
  logic        z_flag = 1'b0;
  logic [7:0]  mbr = 8'h00;
  logic [13:0] mir = 14'h0000;
  logic        stall = 1'b0;
  logic [8:0]  mpc;
  logic [2:0]  depth;
  logic        ovf;
  logic        unf;

  logic [9:0]  mbr_b = 10'h000;
  logic [16:0] mir_b = 17'h00000;
  logic [11:0] mpc_b;
  logic [2:0]  depth_b;
  logic        ovf_b;
  logic        unf_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mic1_sequencer u_dut (
    .clock (clock), .reset (reset), .n_flag (n_flag), .z_flag (z_flag),
    .mbr (mbr), .mir_ctrl (mir), .stall (stall),
    .mpc (mpc), .stack_depth (depth), .stack_ovf (ovf), .stack_unf (unf)
  );

  mic1_sequencer #(.MPC_W(12), .MBR_W(10), .STACK_DEPTH(4)) u_dut_w (
    .clock (clock), .reset (reset), .n_flag (1'b0), .z_flag (1'b0),
    .mbr (mbr_b), .mir_ctrl (mir_b), .stall (1'b0),
    .mpc (mpc_b), .stack_depth (depth_b), .stack_ovf (ovf_b), .stack_unf (unf_b)
  );

  function automatic logic [13:0] mk(input logic [8:0] na, input logic [4:0] f);
    return {na, f};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (mpc !== 9'h000 || depth !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: mpc=%h depth=%0d ovf=%b unf=%b, required 000/0/0/0", mpc, depth, ovf, unf);
    end
    n_checks++;
    if (mpc_b !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_wide: mpc=%h, required 000", mpc_b);
    end
    reset = 1'b1;
    mir = mk(9'h005, F_PLAIN);
    tick();
    n_checks++;
    if (mpc !== 9'h005 || depth !== 3'd0) begin
      n_fail++;
      $display("FAIL first_addr: mpc=%h depth=%0d, required 005/0", mpc, depth);
    end
  endtask

  task automatic test_jam();
    logic [8:0]  exp_mpc [4] = '{9'h112, 9'h012, 9'h112, 9'h012};
    logic [13:0] mirs    [4];
    logic        zs      [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        ns      [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    mirs[0] = mk(9'h012, F_JAMZ);
    mirs[1] = mk(9'h012, F_JAMZ);
    mirs[2] = mk(9'h012, F_JAMN);
    mirs[3] = mk(9'h012, F_JAMN | F_JAMZ);
    for (int i = 0; i < 4; i++) begin
      mir = mirs[i];
      z_flag = zs[i];
      n_flag = ns[i];
      tick();
      n_checks++;
      if (mpc !== exp_mpc[i]) begin
        n_fail++;
        $display("FAIL jam_%0d: mpc=%h, required %h", i, mpc, exp_mpc[i]);
      end
    end
    z_flag = 1'b0;
    n_flag = 1'b0;
  endtask

  task automatic test_jmpc();
    mir = mk(9'h100, F_JMPC);
    mbr = 8'h3C;
    mir_b = {12'h800, F_JMPC};
    mbr_b = 10'h2A5;
    tick();
    n_checks++;
    if (mpc !== 9'h13C) begin
      n_fail++;
      $display("FAIL jmpc: mpc=%h, required 13c", mpc);
    end
    n_checks++;
    if (mpc_b !== 12'hAA5) begin
      n_fail++;
      $display("FAIL jmpc_wide: mpc=%h, required aa5", mpc_b);
    end
    mbr = 8'h00;
    mir_b = 17'h00000;
  endtask

  task automatic test_call_ret();
    mir = mk(9'h020, F_PLAIN);
    tick();
    mir = mk(9'h040, F_CALL);
    tick();
    n_checks++;
    if (mpc !== 9'h040 || depth !== 3'd1) begin
      n_fail++;
      $display("FAIL call: mpc=%h depth=%0d, required 040/1", mpc, depth);
    end
    mir = mk(9'h1EE, F_RET);
    tick();
    n_checks++;
    if (mpc !== 9'h021 || depth !== 3'd0) begin
      n_fail++;
      $display("FAIL ret: mpc=%h depth=%0d, required 021/0", mpc, depth);
    end
  endtask

  task automatic test_overflow();
    logic [8:0] tgt  [5] = '{9'h200, 9'h010, 9'h020, 9'h030, 9'h0AA};
    logic [8:0] rets [4] = '{9'h021, 9'h011, 9'h201, 9'h101};
    mir = mk(9'h100, F_PLAIN);
    tick();
    for (int i = 0; i < 5; i++) begin
      mir = mk(tgt[i], F_CALL);
      tick();
    end
    n_checks++;
    if (mpc !== 9'h0AA || depth !== 3'd4 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: mpc=%h depth=%0d ovf=%b, required 0aa/4/1", mpc, depth, ovf);
    end
    for (int i = 0; i < 4; i++) begin
      mir = mk(9'h1FF, F_RET);
      tick();
      n_checks++;
      if (mpc !== rets[i] || depth !== 3'(3 - i)) begin
        n_fail++;
        $display("FAIL lifo_%0d: mpc=%h depth=%0d, required %h/%0d", i, mpc, depth, rets[i], 3 - i);
      end
    end
  endtask

  task automatic test_underflow();
    mir = mk(9'h077, F_RET);
    tick();
    n_checks++;
    if (mpc !== 9'h077 || unf !== 1'b1 || depth !== 3'd0) begin
      n_fail++;
      $display("FAIL underflow: mpc=%h unf=%b depth=%0d, required 077/1/0", mpc, unf, depth);
    end
    mir = mk(9'h033, F_PLAIN);
    repeat (3) tick();
    n_checks++;
    if (unf !== 1'b1 || ovf !== 1'b1 || mpc !== 9'h033) begin
      n_fail++;
      $display("FAIL sticky: unf=%b ovf=%b mpc=%h, required 1/1/033", unf, ovf, mpc);
    end
  endtask

  task automatic test_swap();
    mir = mk(9'h04F, F_PLAIN);
    tick();
    mir = mk(9'h030, F_CALL);
    tick();
    mir = mk(9'h0EE, F_CALL | F_RET);
    tick();
    n_checks++;
    if (mpc !== 9'h050 || depth !== 3'd1) begin
      n_fail++;
      $display("FAIL swap: mpc=%h depth=%0d, required 050/1", mpc, depth);
    end
    mir = mk(9'h0EE, F_RET);
    tick();
    n_checks++;
    if (mpc !== 9'h031 || depth !== 3'd0) begin
      n_fail++;
      $display("FAIL swap_top: mpc=%h depth=%0d, required 031/0", mpc, depth);
    end
  endtask

  task automatic test_wrap();
    mir = mk(9'h1FF, F_PLAIN);
    tick();
    mir = mk(9'h005, F_CALL);
    tick();
    mir = mk(9'h123, F_RET);
    tick();
    n_checks++;
    if (mpc !== 9'h000 || depth !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap: mpc=%h depth=%0d, required 000/0", mpc, depth);
    end
  endtask

  task automatic test_stall_reset();
    mir = mk(9'h010, F_PLAIN);
    tick();
    mir = mk(9'h020, F_CALL);
    tick();
    mir = mk(9'h040, F_CALL);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (mpc !== 9'h020 || depth !== 3'd1 || ovf !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_%0d: mpc=%h depth=%0d ovf=%b, required 020/1/1", i, mpc, depth, ovf);
      end
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (mpc !== 9'h000 || depth !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: mpc=%h depth=%0d ovf=%b unf=%b, required 000/0/0/0", mpc, depth, ovf, unf);
    end
    @(negedge clock);
    stall = 1'b0;
    reset = 1'b1;
    mir = mk(9'h031, F_PLAIN);
    tick();
    n_checks++;
    if (mpc !== 9'h031) begin
      n_fail++;
      $display("FAIL after_reset: mpc=%h, required 031", mpc);
    end
  endtask

  task automatic test_swap_empty();
    mir = mk(9'h0C0, F_CALL | F_RET);
    tick();
    n_checks++;
    if (mpc !== 9'h0C0 || depth !== 3'd1 || unf !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_empty: mpc=%h depth=%0d unf=%b ovf=%b, required 0c0/1/1/0", mpc, depth, unf, ovf);
    end
    mir = mk(9'h0EE, F_RET);
    tick();
    n_checks++;
    if (mpc !== 9'h032 || depth !== 3'd0) begin
      n_fail++;
      $display("FAIL swap_empty_ret: mpc=%h depth=%0d, required 032/0", mpc, depth);
    end
  endtask

  initial begin
    test_reset();
    test_jam();
    test_jmpc();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_swap();
    test_wrap();
    test_stall_reset();
    test_swap_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
